// File: rtl/dm_arb_pkg.sv
// Shared constants, request bundle and address helper for the data-memory arbiter.
package dm_arb_pkg;

  localparam logic ST_PRIO0  = 1'b0;
  localparam logic ST_FORCE1 = 1'b1;

  localparam int DM_IDX_HI = 11;
  localparam int DM_IDX_LO = 2;
  localparam int DM_WORDS  = 1 << (DM_IDX_HI - DM_IDX_LO + 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
  } dm_req_t;

  function automatic logic [DM_IDX_HI-DM_IDX_LO:0] dm_word_idx(input logic [31:0] addr);
    return addr[DM_IDX_HI:DM_IDX_LO];
  endfunction

endpackage

// File: rtl/dm_arb_wait_cnt.sv
// Saturating count of consecutive contested cycles lost by port 1.
module dm_arb_wait_cnt #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // hit flags the increment that reaches the limit, so the FSM can switch next cycle
  assign hit = inc && !clr && (cnt_q >= (MAX_V - 1'b1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory: fixed priority to port 0 with starvation relief.
// Optional port-1 bus lock is enabled by defining DM_ARB_LOCK_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  input  logic [31:0] pc0,
  input  logic [31:0] pc1,
`ifdef DM_ARB_LOCK_EN
  input  logic        lock1,
`endif
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd
);

  logic        state_q;
  logic        state_d;
  logic        cnt_inc;
  logic        cnt_clr;
  logic        cnt_hit;
  logic        lock_act;
  logic        rvalid0_q;
  logic        rvalid0_d;
  logic        rvalid1_q;
  logic        rvalid1_d;
  logic [31:0] rdata0_q;
  logic [31:0] rdata0_d;
  logic [31:0] rdata1_q;
  logic [31:0] rdata1_d;
  dm_req_t     port0;
  dm_req_t     port1;
  dm_req_t     win;

`ifdef DM_ARB_LOCK_EN
  logic gnt1_prev_q;
  logic gnt1_prev_d;

  assign gnt1_prev_d = gnt1;
  assign lock_act    = gnt1_prev_q & lock1 & req1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt1_prev_q <= 1'b0;
    end else begin
      gnt1_prev_q <= gnt1_prev_d;
    end
  end
`else
  assign lock_act = 1'b0;
`endif

  // Grants are held low throughout reset so nothing reaches the memory.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (reset) begin
      if (lock_act) begin
        gnt1 = 1'b1;
      end else if (state_q == ST_FORCE1) begin
        if (req1) begin
          gnt1    = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          gnt0 = req0;
        end
      end else begin
        if (req0) begin
          gnt0    = 1'b1;
          cnt_inc = req1;
        end else if (req1) begin
          gnt1    = 1'b1;
          cnt_clr = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (lock_act) begin
      state_d = ST_PRIO0;
    end else if (state_q == ST_FORCE1) begin
      if (gnt1) begin
        state_d = ST_PRIO0;
      end
    end else if (cnt_hit) begin
      state_d = ST_FORCE1;
    end
  end

  dm_arb_wait_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .hit   (cnt_hit)
  );

  assign port0 = '{we: we0, addr: addr0, wd: wd0, pc: pc0};
  assign port1 = '{we: we1, addr: addr1, wd: wd1, pc: pc1};

  always_comb begin
    win = port0;
    if (gnt1) begin
      win = port1;
    end
  end

  assign mem_we   = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr = win.addr;
  assign mem_wd   = win.wd;
  assign mem_pc   = win.pc;

  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rd : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_PRIO0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed vectors push expectations, a negedge monitor compares.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1, lock1;
  logic [31:0] addr0, addr1, wd0, wd1, pc0, pc1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wd, mem_pc, mem_rd;

  localparam logic [31:0] A0 = 32'h40;
  localparam logic [31:0] D0 = 32'hA5A5_0000;
  localparam logic [31:0] A1 = 32'h80;
  localparam logic [31:0] D1 = 32'h5A5A_0001;

  typedef struct {
    logic        g0;
    logic        g1;
    logic        mwe;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rv0;
    logic        rv1;
    logic        chkz;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd0_q[$];
  logic [31:0] rd1_q[$];
  int          total;
  int          bad;
  bit          armed;

  dm_arbiter #(.MAX_WAIT(4), .CW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wd0      (wd0),
    .wd1      (wd1),
    .pc0      (pc0),
    .pc1      (pc1),
`ifdef DM_ARB_LOCK_EN
    .lock1    (lock1),
`endif
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_pc   (mem_pc),
    .mem_rd   (mem_rd)
  );

  // Data memory model: combinational read, write at the grant edge.
  logic [31:0] mem [0:DM_WORDS-1];
  always @(posedge clk) begin
    if (!reset) mem[dm_word_idx(32'h20)] <= 32'h1234_5678;
    else if (mem_we) mem[dm_word_idx(mem_addr)] <= mem_wd;
  end
  assign mem_rd = mem[dm_word_idx(mem_addr)];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt0", {31'd0, gnt0}, {31'd0, e.g0});
        check("gnt1", {31'd0, gnt1}, {31'd0, e.g1});
        check("mem_we", {31'd0, mem_we}, {31'd0, e.mwe});
        check("mem_addr", mem_addr, e.addr);
        check("mem_wd", mem_wd, e.wd);
        check("rvalid0", {31'd0, rvalid0}, {31'd0, e.rv0});
        check("rvalid1", {31'd0, rvalid1}, {31'd0, e.rv1});
        if (e.chkz) begin
          check("rdata0_reset", rdata0, 32'd0);
          check("rdata1_reset", rdata1, 32'd0);
        end
      end
      if (rvalid0) begin
        if (rd0_q.size() > 0) check("rdata0", rdata0, rd0_q.pop_front());
        else check("rvalid0_unexpected", {31'd0, rvalid0}, 32'd0);
      end
      if (rvalid1) begin
        if (rd1_q.size() > 0) check("rdata1", rdata1, rd1_q.pop_front());
        else check("rvalid1_unexpected", {31'd0, rvalid1}, 32'd0);
      end
    end
  end

  task automatic step(input logic rst_n,
                      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic lk,
                      input logic eg0, input logic eg1, input logic emwe,
                      input logic [31:0] eaddr, input logic [31:0] ewd,
                      input logic erv0, input logic erv1, input logic chkz);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_n;
    req0 = r0; we0 = w0; addr0 = a0; wd0 = d0; pc0 = 32'h3000;
    req1 = r1; we1 = w1; addr1 = a1; wd1 = d1; pc1 = 32'h0;
    lock1 = lk;
    e.g0 = eg0; e.g1 = eg1; e.mwe = emwe; e.addr = eaddr; e.wd = ewd;
    e.rv0 = erv0; e.rv1 = erv1; e.chkz = chkz;
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  // Both ports request writes; expected grants are supplied per cycle.
  task automatic contend(input logic rst_n, input logic r1, input logic eg0, input logic eg1);
    step(rst_n, 1'b1, 1'b1, A0, D0, r1, 1'b1, A1, D1, 1'b0,
         eg0, eg1, eg0 | eg1, eg1 ? A1 : A0, eg1 ? D1 : D0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    armed = 1'b0;
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wd0 = 32'hDEAD_BEEF; pc0 = 32'h3000;
    req1 = 1'b1; we1 = 1'b1; addr1 = A1; wd1 = 32'h0; pc1 = 32'h0;
    lock1 = 1'b0;

    // Reset with both ports requesting writes
    repeat (2)
      step(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, A1, 32'h0, 1'b0,
           1'b0, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);

    // Port 0 write then read back
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
         1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
         1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    rd0_q.push_back(32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
         1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);

    // Port 1 alone reads 0x20 twice
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0,
         1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    rd1_q.push_back(32'h1234_5678);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0,
         1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
    rd1_q.push_back(32'h1234_5678);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0,
         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Starvation: four losses, forced port-1 win, then port 0 again
    repeat (4) contend(1'b1, 1'b1, 1'b1, 1'b0);
    contend(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) contend(1'b1, 1'b1, 1'b1, 1'b0);
    // Forced state with port 1 absent lets port 0 through and keeps waiting
    contend(1'b1, 1'b0, 1'b1, 1'b0);
    contend(1'b1, 1'b1, 1'b0, 1'b1);

    // Three losses, reset, then a full four losses are needed again
    repeat (3) contend(1'b1, 1'b1, 1'b1, 1'b0);
    contend(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) contend(1'b1, 1'b1, 1'b1, 1'b0);
    contend(1'b1, 1'b1, 1'b0, 1'b1);
    contend(1'b1, 1'b1, 1'b1, 1'b0);

`ifdef DM_ARB_LOCK_EN
    // Port 1 locks the memory for three cycles while port 0 waits
    step(1'b1, 1'b0, 1'b1, A0, D0, 1'b1, 1'b1, A1, D1, 1'b1,
         1'b0, 1'b1, 1'b1, A1, D1, 1'b0, 1'b0, 1'b0);
    repeat (2)
      step(1'b1, 1'b1, 1'b1, A0, D0, 1'b1, 1'b1, A1, D1, 1'b1,
           1'b0, 1'b1, 1'b1, A1, D1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, A0, D0, 1'b1, 1'b1, A1, D1, 1'b0,
         1'b1, 1'b0, 1'b1, A0, D0, 1'b0, 1'b0, 1'b0);
`endif

    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("rd0_q_drained", rd0_q.size(), 32'd0);
    check("rd1_q_drained", rd1_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port 1024-word data memory between two requesters: port 0 (pipeline MEM stage) and port 1 (DMA/debug loader).
- Sits between the requesters and the data memory; drives the memory's WE, addr, WD and pc inputs and receives its combinational RD.
- Fixed priority to port 0, with a starvation counter that forces one port-1 grant after MAX_WAIT consecutive port-1 losses.
- At most one memory access per cycle; read data returns registered one cycle after grant.

Parameters:
- MAX_WAIT, 4, consecutive contested cycles port 1 may lose before it is forced to win (legal range 1..15).
- CW, 4, width of the starvation counter; must satisfy 2^CW > MAX_WAIT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- req0, req1  in  1  access request, ports 0/1.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  32  byte address; only [11:2] is used by the memory.
- wd0, wd1  in  32  write data.
- pc0, pc1  in  32  PC tag forwarded to the memory for write logging; port 1 drives 0.
- gnt0, gnt1  out  1  combinational grant; the access completes at this clock edge.
- rvalid0, rvalid1  out  1  registered; read data valid, one cycle after a read grant.
- rdata0, rdata1  out  32  registered read data.
- mem_we  out  1  memory write enable.
- mem_addr, mem_wd, mem_pc  out  32  memory address, write data and PC, muxed from the winner.
- mem_rd  in  32  memory combinational read data.

Behaviour:
- Handshake:
  - A requester holds req and payload stable until it sees gnt.
  - gnt is combinational in the same cycle.
  - A request dropped without a grant is legal and has no effect.
- FSM, 2 states:
  - PRIO0 (reset state): if req0, port 0 wins. Otherwise, if req1, port 1 wins.
  - FORCE1: if req1, port 1 wins regardless of req0, then go to PRIO0. If !req1, port 0 may win and the FSM stays in FORCE1.
- Starvation counter wait_cnt (CW bits, reset 0):
  - In PRIO0, increments when req1 && gnt0.
  - Clears whenever gnt1.
  - When the increment brings it to MAX_WAIT, the next state is FORCE1.
  - Saturates at MAX_WAIT and never wraps.
- Memory mux:
  - mem_addr, mem_wd and mem_pc follow the winner; they follow port 0 when idle.
  - mem_we = (gnt0 & we0) | (gnt1 & we1).
  - mem_we is never 1 without a grant.
- Read return:
  - On a read grant for port n, rdata_n <= mem_rd and rvalid_n <= 1 at that edge.
  - Otherwise rvalid_n <= 0 and rdata_n holds its value.
- Simultaneous events:
  - Only one gnt is high per cycle. gnt0 & gnt1 == 0 always.
  - A write grant produces no rvalid.
- Reset:
  - When reset == 0 at a clock edge: state=PRIO0, wait_cnt=0, rvalid0/1=0, rdata0/1=0.
  - gnt0, gnt1 and mem_we are forced to 0 combinationally while reset==0, so no memory write occurs during reset.
  - A request pending across reset is re-arbitrated from PRIO0 afterwards.
- Latency:
  - Write: 0 cycles (committed at the grant edge).
  - Read: rvalid 1 cycle after the grant.

Optional Feature:
- Macro: DM_ARB_LOCK_EN.
- With the macro:
  - Adds input lock1 (1 bit).
  - While port 1 was granted in the previous cycle and lock1 and req1 are both 1, port 1 keeps the grant and port 0 stalls.
  - wait_cnt is held during the lock.
  - Deasserting lock1 returns to PRIO0.
- Without the macro: no lock1 port; arbitration exactly as above.

Decomposition:
- Shared package dm_arb_pkg holds:
  - the state encoding constants ST_PRIO0=1'b0 and ST_FORCE1=1'b1;
  - the memory index range constants (DM_IDX_HI=11, DM_IDX_LO=2).
- One natural sub-module, dm_arb_wait_cnt: the saturating starvation counter with inc/clr/hit outputs.

Test Plan:
- Reset: reset=0 for 2 cycles with req0=req1=1, we0=1 -> gnt0=gnt1=0, mem_we=0, rvalid0/1=0, rdata0/1=0.
- Port-0 write then read:
  - req0, we0=1, addr0=0x10, wd0=0xDEADBEEF, pc0=0x3000 -> gnt0=1, mem_we=1, mem_addr=0x10 in the same cycle.
  - Next cycle, read of 0x10 -> rvalid0=1, rdata0=0xDEADBEEF one cycle later.
- Starvation:
  - req0 and req1 held high, MAX_WAIT=4 -> gnt0 for 4 cycles, gnt1 on cycle 5, gnt0 on cycle 6.
  - wait_cnt returns to 0 after the gnt1.
- Idle port 0: req1 alone with a read of 0x20 containing 0x12345678 -> gnt1 every cycle, rvalid1=1, rdata1=0x12345678 one cycle later, rvalid0 stays 0.
- Reset mid-operation: wait_cnt=3 with req1 pending, reset=0 for 1 cycle -> after release, port 0 wins and port 1 needs 4 more losses before its forced grant.
- DM_ARB_LOCK_EN: port 1 granted with lock1=1 for 3 cycles while req0=1 -> gnt1 on 3 consecutive cycles, then gnt0 once lock1=0.
